// File: rtl/up_down_scheduler.sv
// Round-robin owner of a shared up/down counter: two requesters each ask for a run of N
// single steps in a chosen direction; the granted run always completes before re-arbitration.
module up_down_scheduler #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [1:0]       dir_req,
   input  logic [WIDTH-1:0] steps0,
   input  logic [WIDTH-1:0] steps1,
   output logic [1:0]       grant,
   output logic             busy,
   output logic             done,
   output logic             up_down_sw,
   output logic             cnt_en,
   output logic [WIDTH-1:0] count
);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] remain_q, remain_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             last_q, last_d;
   logic             win;

   // On a tie the requester that was not served last wins.
   assign win = (req == 2'b11) ? ~last_q : req[1];

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      dir_d    = dir_q;
      remain_d = remain_q;
      count_d  = count_q;
      last_d   = last_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d  = StLoad;
               grant_d  = win ? 2'b10 : 2'b01;
               dir_d    = dir_req[win];
               remain_d = win ? steps1 : steps0;
               last_d   = win;
            end
         end
         StLoad: begin
            state_d = (remain_q == '0) ? StDone : StRun;
         end
         StRun: begin
            count_d  = dir_q ? count_q + 1'b1 : count_q - 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == WIDTH'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            grant_d = 2'b00;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         grant_q  <= 2'b00;
         dir_q    <= 1'b0;
         remain_q <= '0;
         count_q  <= '0;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         dir_q    <= dir_d;
         remain_q <= remain_d;
         count_q  <= count_d;
         last_q   <= last_d;
      end
   end

   assign grant      = grant_q;
   assign busy       = |grant_q;
   assign done       = (state_q == StDone);
   assign cnt_en     = (state_q == StRun);
   assign up_down_sw = dir_q;
   assign count      = count_q;

endmodule

// File: tb/tb_up_down_scheduler.sv
// Bench for up_down_scheduler: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a run-timeline model of the scheduler.
module tb_up_down_scheduler;

   logic       clk;
   logic       reset;
   logic [1:0] req;
   logic [1:0] dir_req;
   logic [3:0] steps0;
   logic [3:0] steps1;
   logic [1:0] grant;
   logic       busy;
   logic       done;
   logic       up_down_sw;
   logic       cnt_en;
   logic [3:0] count;

   up_down_scheduler #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .dir_req    (dir_req),
      .steps0     (steps0),
      .steps1     (steps1),
      .grant      (grant),
      .busy       (busy),
      .done       (done),
      .up_down_sw (up_down_sw),
      .cnt_en     (cnt_en),
      .count      (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a granted run is a timeline t = 0 .. N+1 of grant cycles; the counter steps in
   // cycles 1..N and the final cycle is the done pulse. Then at least one idle cycle.
   bit         m_active = 1'b0;
   bit   [1:0] m_grant = 2'b00;
   bit         m_dir = 1'b0;
   bit   [3:0] m_count = 4'h0;
   bit         m_last = 1'b1;
   int         m_t = 0;
   int         m_n = 0;
   bit         started = 1'b0;

   function automatic bit pick(input logic [1:0] r, input bit last);
      if (r == 2'b11) return !last;
      return r[1];
   endfunction

   always @(posedge clk) begin
      started <= 1'b1;
      if (!reset) begin
         m_active <= 1'b0;
         m_grant  <= 2'b00;
         m_dir    <= 1'b0;
         m_count  <= 4'h0;
         m_last   <= 1'b1;
         m_t      <= 0;
         m_n      <= 0;
      end else if (m_active) begin
         if (m_t >= 1 && m_t <= m_n) m_count <= m_dir ? m_count + 4'd1 : m_count - 4'd1;
         if (m_t == m_n + 1) begin
            m_active <= 1'b0;
            m_grant  <= 2'b00;
         end else begin
            m_t <= m_t + 1;
         end
      end else if (req != 2'b00) begin
         m_active <= 1'b1;
         m_t      <= 0;
         m_grant  <= pick(req, m_last) ? 2'b10 : 2'b01;
         m_dir    <= dir_req[pick(req, m_last)];
         m_n      <= pick(req, m_last) ? int'(steps1) : int'(steps0);
         m_last   <= pick(req, m_last);
      end
   end

   function automatic bit exp_done();
      return m_active && (m_t == m_n + 1);
   endfunction

   function automatic bit exp_cnt_en();
      return m_active && (m_t >= 1) && (m_t <= m_n);
   endfunction

   always @(negedge clk) begin
      if (started) begin
         check("grant", {6'd0, grant}, {6'd0, m_grant});
         check("busy", {7'd0, busy}, {7'd0, m_active});
         check("done", {7'd0, done}, {7'd0, exp_done()});
         check("cnt_en", {7'd0, cnt_en}, {7'd0, exp_cnt_en()});
         check("up_down_sw", {7'd0, up_down_sw}, {7'd0, m_dir});
         check("count", {4'd0, count}, {4'd0, m_count});
      end
   end

   // Waits (bounded) for a grant, then observes the whole run. Returns at the first idle
   // negedge after the run. keep=0 drops the owner's req on done; mess scrambles inputs mid-run.
   task automatic wait_run(input bit keep, input bit mess, output int w, output int gc,
                           output int nd, output int ne, output logic [3:0] cd,
                           output logic [1:0] who);
      w = 0; gc = 0; nd = 0; ne = 0; cd = 4'hx; who = 2'b00;
      for (int k = 0; k < 40 && grant == 2'b00; k++) begin
         w++;
         @(negedge clk);
      end
      if (grant == 2'b00) begin
         check("grant_timeout", {6'd0, grant}, 8'h01);
      end else begin
         who = grant;
         for (int k = 0; k < 40 && grant != 2'b00; k++) begin
            gc++;
            if (cnt_en) ne++;
            if (done) begin
               nd++;
               cd = count;
               if (!keep) req = req & ~who;
            end
            if (mess && gc == 2) begin
               req     = 2'b00;
               dir_req = ~dir_req;
               steps0  = 4'd1;
               steps1  = 4'd1;
            end
            @(negedge clk);
         end
         check("run_end_timeout", {6'd0, grant}, 8'h00);
      end
   endtask

   int         w, gc, nd, ne;
   logic [3:0] cd;
   logic [1:0] who;

   initial begin
      reset = 1'b0; req = 2'b00; dir_req = 2'b00; steps0 = 4'd0; steps1 = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_grant", {6'd0, grant}, 8'h00);
      check("rst_count", {4'd0, count}, 8'h00);
      check("rst_sw", {7'd0, up_down_sw}, 8'h00);

      // Single up run of 3.
      reset = 1'b1; req = 2'b01; dir_req = 2'b01; steps0 = 4'd3;
      wait_run(1'b0, 1'b0, w, gc, nd, ne, cd, who);
      check("t1_who", {6'd0, who}, 8'h01);
      check("t1_gc", 8'(gc), 8'd5);
      check("t1_ne", 8'(ne), 8'd3);
      check("t1_nd", 8'(nd), 8'd1);
      check("t1_cd", {4'd0, cd}, 8'h03);

      // Down 2 to reach 1, then down 3 wrapping to E.
      req = 2'b10; dir_req = 2'b00; steps1 = 4'd2;
      wait_run(1'b0, 1'b0, w, gc, nd, ne, cd, who);
      check("t2a_cd", {4'd0, cd}, 8'h01);
      req = 2'b10; steps1 = 4'd3;
      wait_run(1'b0, 1'b0, w, gc, nd, ne, cd, who);
      check("t2_who", {6'd0, who}, 8'h02);
      check("t2_cd", {4'd0, cd}, 8'h0E);

      // Zero steps.
      req = 2'b01; dir_req = 2'b01; steps0 = 4'd0;
      wait_run(1'b0, 1'b0, w, gc, nd, ne, cd, who);
      check("t3_gc", 8'(gc), 8'd2);
      check("t3_ne", 8'(ne), 8'd0);
      check("t3_nd", 8'(nd), 8'd1);
      check("t3_cd", {4'd0, cd}, 8'h0E);

      // Contention fairness with both requests held.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("t4_rst_count", {4'd0, count}, 8'h00);
      req = 2'b11; dir_req = 2'b11; steps0 = 4'd2; steps1 = 4'd2;
      wait_run(1'b1, 1'b0, w, gc, nd, ne, cd, who);
      check("t4a_who", {6'd0, who}, 8'h01);
      check("t4a_cd", {4'd0, cd}, 8'h02);
      wait_run(1'b1, 1'b0, w, gc, nd, ne, cd, who);
      check("t4b_who", {6'd0, who}, 8'h02);
      check("t4b_gap", 8'(w), 8'd1);
      check("t4b_cd", {4'd0, cd}, 8'h04);
      wait_run(1'b1, 1'b0, w, gc, nd, ne, cd, who);
      req = 2'b00;
      check("t4c_who", {6'd0, who}, 8'h01);
      check("t4c_gap", 8'(w), 8'd1);
      check("t4c_cd", {4'd0, cd}, 8'h06);

      // Mid-run input changes ignored.
      req = 2'b01; dir_req = 2'b01; steps0 = 4'd5;
      wait_run(1'b0, 1'b1, w, gc, nd, ne, cd, who);
      check("t5_gc", 8'(gc), 8'd7);
      check("t5_ne", 8'(ne), 8'd5);
      check("t5_nd", 8'(nd), 8'd1);
      check("t5_cd", {4'd0, cd}, 8'h0B);

      // Reset mid-run at count 6.
      req = 2'b10; dir_req = 2'b00; steps1 = 4'd5;
      wait_run(1'b0, 1'b0, w, gc, nd, ne, cd, who);
      check("t6a_cd", {4'd0, cd}, 8'h06);
      req = 2'b01; dir_req = 2'b01; steps0 = 4'd8;
      for (int k = 0; k < 10 && grant == 2'b00; k++) @(negedge clk);
      @(negedge clk);
      check("t6_cnt_en", {7'd0, cnt_en}, 8'h01);
      check("t6_count6", {4'd0, count}, 8'h06);
      reset = 1'b0;
      @(negedge clk);
      check("t6_count", {4'd0, count}, 8'h00);
      check("t6_grant", {6'd0, grant}, 8'h00);
      check("t6_done", {7'd0, done}, 8'h00);
      check("t6_sw", {7'd0, up_down_sw}, 8'h00);
      reset = 1'b1; req = 2'b11; dir_req = 2'b11; steps0 = 4'd1; steps1 = 4'd1;
      wait_run(1'b0, 1'b0, w, gc, nd, ne, cd, who);
      req = 2'b00;
      check("t6_tie_who", {6'd0, who}, 8'h01);

      // Random traffic; the per-cycle compare against the model does the checking.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
               if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
            end
         end
         dir_req = 2'($urandom_range(0, 3));
         steps0  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 4));
         steps1  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 4));
      end
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
